// File: rtl/general.sv
// Shared definitions for the evaluator memory subsystem: machine word size
// and the status code returned alongside every RAM access.
package general;

  localparam int WORD_SIZE = 32;

  typedef enum logic [0:0] {
    mem_ok  = 1'b0,
    mem_oob = 1'b1
  } mem_status_t;

endpackage

// File: rtl/mem_fetch.sv
// mem_fetch: requester-side controller for the single-port registered RAM.
// Takes word read, word write and cons-cell read requests from the evaluator
// core, sequences the RAM strobes, captures q/status and reports the result
// with a one-cycle done pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and is a pure
// function of state (no path from req_valid). While busy, req_valid is
// ignored; the requester keeps the request asserted until it transfers.
// Results on rsp_* are valid from the done cycle and hold until the next
// transfer, which clears them.
module mem_fetch
  import general::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = WORD_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [WORD_W-1:0] ram_data,
  input  logic [WORD_W-1:0] ram_q,
  input  mem_status_t       ram_status,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rsp_data0,
  output logic [WORD_W-1:0] rsp_data1,
  output mem_status_t       rsp_status,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_CAPT0  = 3'd2,
    S_CAPT1  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_CELL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_inc;
  logic              addr_wrap;
  logic              is_cell;

  // Second word of a cell; wraps naturally at the top of the address space.
  assign addr_inc  = addr_q + ADDR_ONE;
  assign addr_wrap = (addr_q == {ADDR_W{1'b1}});
  assign is_cell   = (op_q == OP_CELL);

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign state_dbg = state_q;

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; the illegal op skips the RAM and completes at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (req_op == OP_ILL) ? S_DONE : S_ISSUE0;
        end
      end
      S_ISSUE0: state_d = S_CAPT0;
      S_CAPT0:  state_d = is_cell ? S_CAPT1 : S_DONE;
      S_CAPT1:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // RAM strobes and done decode from state and the latched request only.
  // The cdr read overlaps the car capture; it is dropped when addr+1 wraps.
  always_comb begin
    ram_addr = '0;
    ram_rden = 1'b0;
    ram_wren = 1'b0;
    ram_data = '0;
    done     = 1'b0;
    case (state_q)
      S_ISSUE0: begin
        ram_addr = addr_q;
        if (op_q == OP_WR) begin
          ram_wren = 1'b1;
          ram_data = wdata_q;
        end else begin
          ram_rden = 1'b1;
        end
      end
      S_CAPT0: begin
        if (is_cell && !addr_wrap) begin
          ram_rden = 1'b1;
          ram_addr = addr_inc;
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Request latch and response capture. Data from an out-of-range access is
  // kept as returned; rsp_status tells the consumer whether to trust it.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data0  <= '0;
      rsp_data1  <= '0;
      rsp_status <= mem_ok;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rsp_data0  <= '0;
            rsp_data1  <= '0;
            rsp_status <= (req_op == OP_ILL) ? mem_oob : mem_ok;
          end
        end
        S_CAPT0: begin
          if (op_q != OP_WR) begin
            rsp_data0 <= ram_q;
          end
          if (is_cell && addr_wrap) begin
            rsp_status <= mem_oob;
          end else begin
            rsp_status <= ram_status;
          end
        end
        S_CAPT1: begin
          if (!addr_wrap) begin
            rsp_data1 <= ram_q;
            if (ram_status == mem_oob) begin
              rsp_status <= mem_oob;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fetch.sv
// Bench for mem_fetch: a registered 128-word RAM model on the RAM side, a
// request driver, and a word-level reference model of what each op returns.
module tb_mem_fetch;
  import general::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  ram_addr;
  logic        ram_rden;
  logic        ram_wren;
  logic [31:0] ram_data;
  logic [31:0] ram_q;
  mem_status_t ram_status;
  logic        busy;
  logic        done;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;
  mem_status_t rsp_status;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  mem_fetch #(.ADDR_W(8), .WORD_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_q(ram_q), .ram_status(ram_status),
    .busy(busy), .done(done), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_status(rsp_status), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: 128 words, one-cycle read latency, out-of-range returns word 0
  logic [31:0] ram_mem [128];
  always @(posedge clk) begin
    if (ram_rden) begin
      if (ram_addr < 8'd128) begin
        ram_q      <= ram_mem[ram_addr[6:0]];
        ram_status <= mem_ok;
      end else begin
        ram_q      <= ram_mem[0];
        ram_status <= mem_oob;
      end
    end
    if (ram_wren) begin
      if (ram_addr < 8'd128) begin
        ram_mem[ram_addr[6:0]] <= ram_data;
        ram_status <= mem_ok;
      end else begin
        ram_status <= mem_oob;
      end
    end
  end

  // reference model state and expectations
  logic [31:0] ref_mem [128];
  logic [7:0]  exp_q[$];
  int          exp_lat;
  int          exp_nwr;
  logic [31:0] exp_d0, exp_d1;
  mem_status_t exp_st;

  // observations from the driver
  logic [7:0]  obs_rd_q[$];
  int          obs_lat;
  int          obs_nwr;
  int          obs_both;
  logic [7:0]  obs_wr_addr;
  logic [31:0] obs_wr_data;
  logic [31:0] obs_d0, obs_d1;
  mem_status_t obs_st;

  // Word-level semantics of one op: what each returns and which addresses get read.
  function automatic void model_op(input logic [1:0] op, input logic [7:0] a,
                                   input logic [31:0] wd);
    logic [7:0] b;
    exp_q.delete();
    exp_d0 = '0; exp_d1 = '0; exp_st = mem_ok; exp_nwr = 0; exp_lat = 1;
    case (op)
      2'b00: begin
        exp_lat = 3;
        exp_q.push_back(a);
        if (a < 128) exp_d0 = ref_mem[a[6:0]];
        else begin exp_d0 = ref_mem[0]; exp_st = mem_oob; end
      end
      2'b01: begin
        exp_lat = 3;
        exp_nwr = 1;
        if (a < 128) ref_mem[a[6:0]] = wd;
        else exp_st = mem_oob;
      end
      2'b10: begin
        exp_lat = 4;
        exp_q.push_back(a);
        if (a < 128) exp_d0 = ref_mem[a[6:0]];
        else begin exp_d0 = ref_mem[0]; exp_st = mem_oob; end
        if (a == 8'hFF) exp_st = mem_oob;
        else begin
          b = a + 8'd1;
          exp_q.push_back(b);
          if (b < 128) exp_d1 = ref_mem[b[6:0]];
          else begin exp_d1 = ref_mem[0]; exp_st = mem_oob; end
        end
      end
      default: begin
        exp_lat = 1;
        exp_st  = mem_oob;
      end
    endcase
  endfunction

  // Drive one request, then watch strobes each cycle until done (bounded).
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd);
    int j;
    obs_rd_q.delete();
    obs_nwr = 0; obs_both = 0; obs_lat = 0;
    obs_wr_addr = '0; obs_wr_data = '0;
    @(negedge clk);
    j = 0;
    while (!req_ready && j < 20) begin
      @(negedge clk);
      j++;
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (ram_rden) obs_rd_q.push_back(ram_addr);
      if (ram_wren) begin
        obs_nwr++;
        obs_wr_addr = ram_addr;
        obs_wr_data = ram_data;
      end
      if (ram_rden && ram_wren) obs_both++;
      if (done) begin
        obs_lat = j;
        break;
      end
    end
    obs_d0 = rsp_data0; obs_d1 = rsp_data1; obs_st = rsp_status;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_ready got ready=%b busy=%b exp 1/0", req_ready, busy); end
    total++; if (done !== 1'b0 || ram_rden !== 1'b0 || ram_wren !== 1'b0) begin bad++; $display("FAIL rst_strobes got done=%b rden=%b wren=%b exp 0", done, ram_rden, ram_wren); end
    total++; if (ram_addr !== 8'd0 || ram_data !== 32'd0) begin bad++; $display("FAIL rst_ram got addr=%h data=%h exp 0", ram_addr, ram_data); end
    total++; if (rsp_data0 !== 32'd0 || rsp_data1 !== 32'd0 || rsp_status !== mem_ok) begin bad++; $display("FAIL rst_rsp got %h %h %0d exp 0 0 0", rsp_data0, rsp_data1, rsp_status); end
  endtask

  // Fill the whole RAM through the controller so every word is defined.
  task automatic test_fill();
    int errs;
    logic [31:0] wd;
    errs = 0;
    for (int i = 0; i < 128; i++) begin
      wd = $urandom;
      model_op(2'b01, i[7:0], wd);
      run_op(2'b01, i[7:0], wd);
      if (obs_lat != 3 || obs_st !== mem_ok || obs_nwr != 1 || obs_wr_addr !== i[7:0] || obs_wr_data !== wd || obs_rd_q.size() != 0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL fill_writes got errors=%0d exp 0", errs); end
  endtask

  task automatic test_write_read();
    model_op(2'b01, 8'd5, 32'hDEADBEEF);
    run_op(2'b01, 8'd5, 32'hDEADBEEF);
    total++; if (obs_lat != 3) begin bad++; $display("FAIL wr_lat got %0d exp 3", obs_lat); end
    total++; if (obs_st !== mem_ok || obs_d0 !== 32'd0) begin bad++; $display("FAIL wr_rsp got st=%0d d0=%h exp 0 0", obs_st, obs_d0); end
    total++; if (obs_nwr != 1 || obs_wr_addr !== 8'd5 || obs_wr_data !== 32'hDEADBEEF || obs_rd_q.size() != 0) begin bad++; $display("FAIL wr_strobe got nwr=%0d addr=%h data=%h nrd=%0d", obs_nwr, obs_wr_addr, obs_wr_data, obs_rd_q.size()); end
    @(negedge clk);
    total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_pulse got done=%b ready=%b exp 0 1", done, req_ready); end
    model_op(2'b00, 8'd5, '0);
    run_op(2'b00, 8'd5, '0);
    total++; if (obs_lat != 3) begin bad++; $display("FAIL rd_lat got %0d exp 3", obs_lat); end
    total++; if (obs_d0 !== 32'hDEADBEEF || obs_st !== mem_ok || obs_d1 !== 32'd0) begin bad++; $display("FAIL rd_rsp got d0=%h d1=%h st=%0d exp deadbeef 0 0", obs_d0, obs_d1, obs_st); end
    total++; if (obs_rd_q.size() != 1 || obs_nwr != 0) begin bad++; $display("FAIL rd_strobe got nrd=%0d nwr=%0d exp 1 0", obs_rd_q.size(), obs_nwr); end
    else begin total++; if (obs_rd_q[0] !== 8'd5) begin bad++; $display("FAIL rd_addr got %h exp 05", obs_rd_q[0]); end end
    // response holds while idle
    repeat (3) @(negedge clk);
    total++; if (rsp_data0 !== 32'hDEADBEEF || rsp_status !== mem_ok) begin bad++; $display("FAIL rd_hold got %h %0d exp deadbeef 0", rsp_data0, rsp_status); end
  endtask

  task automatic test_cell();
    model_op(2'b01, 8'd10, 32'h11); run_op(2'b01, 8'd10, 32'h11);
    model_op(2'b01, 8'd11, 32'h22); run_op(2'b01, 8'd11, 32'h22);
    model_op(2'b10, 8'd10, '0);
    run_op(2'b10, 8'd10, '0);
    total++; if (obs_lat != 4) begin bad++; $display("FAIL cell_lat got %0d exp 4", obs_lat); end
    total++; if (obs_d0 !== 32'h11 || obs_d1 !== 32'h22 || obs_st !== mem_ok) begin bad++; $display("FAIL cell_rsp got %h %h %0d exp 11 22 0", obs_d0, obs_d1, obs_st); end
    total++; if (obs_rd_q.size() != 2 || obs_both != 0) begin bad++; $display("FAIL cell_nrd got %0d both=%0d exp 2 0", obs_rd_q.size(), obs_both); end
    else begin total++; if (obs_rd_q[0] !== 8'd10 || obs_rd_q[1] !== 8'd11) begin bad++; $display("FAIL cell_addr got %h %h exp 0a 0b", obs_rd_q[0], obs_rd_q[1]); end end
  endtask

  task automatic test_oob();
    model_op(2'b00, 8'd200, '0);
    run_op(2'b00, 8'd200, '0);
    total++; if (obs_st !== mem_oob || obs_d0 !== ref_mem[0] || obs_lat != 3) begin bad++; $display("FAIL oob_rd got st=%0d d0=%h lat=%0d exp 1 %h 3", obs_st, obs_d0, obs_lat, ref_mem[0]); end
    model_op(2'b10, 8'd127, '0);
    run_op(2'b10, 8'd127, '0);
    total++; if (obs_st !== mem_oob || obs_d0 !== ref_mem[127] || obs_d1 !== exp_d1 || obs_lat != 4) begin bad++; $display("FAIL oob_cell got st=%0d d0=%h d1=%h lat=%0d exp 1 %h %h 4", obs_st, obs_d0, obs_d1, obs_lat, ref_mem[127], exp_d1); end
  endtask

  task automatic test_wrap();
    model_op(2'b10, 8'hFF, '0);
    run_op(2'b10, 8'hFF, '0);
    total++; if (obs_rd_q.size() != 1) begin bad++; $display("FAIL wrap_nrd got %0d exp 1", obs_rd_q.size()); end
    total++; if (obs_lat != 4 || obs_st !== mem_oob || obs_d1 !== 32'd0 || obs_d0 !== ref_mem[0]) begin bad++; $display("FAIL wrap_rsp got lat=%0d st=%0d d0=%h d1=%h exp 4 1 %h 0", obs_lat, obs_st, obs_d0, obs_d1, ref_mem[0]); end
  endtask

  task automatic test_illegal();
    model_op(2'b11, 8'd3, 32'h5555);
    run_op(2'b11, 8'd3, 32'h5555);
    total++; if (obs_lat != 1) begin bad++; $display("FAIL ill_lat got %0d exp 1", obs_lat); end
    total++; if (obs_st !== mem_oob || obs_d0 !== 32'd0 || obs_d1 !== 32'd0) begin bad++; $display("FAIL ill_rsp got %0d %h %h exp 1 0 0", obs_st, obs_d0, obs_d1); end
    total++; if (obs_rd_q.size() != 0 || obs_nwr != 0) begin bad++; $display("FAIL ill_strobe got nrd=%0d nwr=%0d exp 0 0", obs_rd_q.size(), obs_nwr); end
  endtask

  // Request held through a read: the second transfer happens only after DONE.
  task automatic test_busy_hold();
    int k, done_at, j;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 8'd20; req_wdata = '0;
    @(posedge clk);
    k = 0; done_at = 0;
    do begin
      @(negedge clk);
      k++;
      if (done) done_at = k;
    end while (!req_ready && k < 20);
    total++; if (k != 4 || done_at != 3) begin bad++; $display("FAIL busy_gap got ready_at=%0d done_at=%0d exp 4 3", k, done_at); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    model_op(2'b00, 8'd20, '0);
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!done && j < 20);
    total++; if (j != 3 || rsp_data0 !== exp_d0 || rsp_status !== mem_ok) begin bad++; $display("FAIL busy_second got lat=%0d d0=%h exp 3 %h", j, rsp_data0, exp_d0); end
  endtask

  task automatic test_reset_mid_cell();
    int nd;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'd10; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (ram_rden !== 1'b1 || ram_addr !== 8'd11) begin bad++; $display("FAIL mid_capt0 got rden=%b addr=%h exp 1 0b", ram_rden, ram_addr); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (req_ready !== 1'b1 || ram_rden !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst got ready=%b rden=%b done=%b exp 1 0 0", req_ready, ram_rden, done); end
    total++; if (rsp_data0 !== 32'd0 || rsp_data1 !== 32'd0 || rsp_status !== mem_ok) begin bad++; $display("FAIL mid_rsp got %h %h %0d exp 0 0 0", rsp_data0, rsp_data1, rsp_status); end
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL mid_nodone got %0d pulses exp 0", nd); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [7:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 8'd127;
        1: a = 8'hFF;
        2: a = 8'($urandom_range(128, 254));
        default: a = 8'($urandom_range(0, 126));
      endcase
      wd = $urandom;
      model_op(op, a, wd);
      run_op(op, a, wd);
      total++;
      if (obs_lat != exp_lat || obs_d0 !== exp_d0 || obs_d1 !== exp_d1 || obs_st !== exp_st ||
          obs_nwr != exp_nwr || obs_rd_q != exp_q || obs_both != 0 ||
          (exp_nwr == 1 && (obs_wr_addr !== a || obs_wr_data !== wd))) begin
        bad++;
        $display("FAIL rand_%0d op=%0d a=%h got lat=%0d d0=%h d1=%h st=%0d nwr=%0d nrd=%0d exp lat=%0d d0=%h d1=%h st=%0d nwr=%0d nrd=%0d",
                 i, op, a, obs_lat, obs_d0, obs_d1, obs_st, obs_nwr, obs_rd_q.size(),
                 exp_lat, exp_d0, exp_d1, exp_st, exp_nwr, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_cell();
    test_oob();
    test_wrap();
    test_illegal();
    test_busy_hold();
    test_reset_mid_cell();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fetch.md
Name: mem_fetch

Overview:
- Requester-side controller for the single-port registered RAM (rden/wren/addr/data in, q/status out, one-cycle read latency).
- Accepts word read, word write and cons-cell read (two consecutive words) requests from the evaluator core.
- Sequences the RAM strobes and captures q/status.
- Owns the op busy/done handshake, reporting data plus a mem_status_t (mem_ok/mem_oob from package general).

Parameters:
ADDR_W, 8, RAM address width
WORD_W, WORD_SIZE, data word width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_op  in  2  00 read word, 01 write word, 10 read cell, 11 illegal
req_addr  in  ADDR_W  target address (cell: car at addr, cdr at addr+1)
req_wdata  in  WORD_W  write data
ram_addr  out  ADDR_W  RAM address
ram_rden  out  1  RAM read strobe
ram_wren  out  1  RAM write strobe
ram_data  out  WORD_W  RAM write data
ram_q  in  WORD_W  RAM read data, valid the cycle after rden
ram_status  in  mem_status_t  RAM status, valid the cycle after rden/wren
busy  out  1  equals !req_ready
done  out  1  one-cycle completion pulse
rsp_data0  out  WORD_W  word read / car
rsp_data1  out  WORD_W  cdr (cell reads only, else 0)
rsp_status  out  mem_status_t  completion status

Behaviour:
- Reset (any state, including mid-operation):
  - State returns to IDLE next edge.
  - done=0; ram_rden=ram_wren=0; ram_addr=0; ram_data=0.
  - rsp_data0=rsp_data1=0; rsp_status=mem_ok.
  - No done pulse for an aborted op.
- States: IDLE, ISSUE0, CAPT0, CAPT1, DONE.
- Accept: req_valid && req_ready at edge N.
  - Latch op, addr and wdata.
  - Clear rsp_data0, rsp_data1 and rsp_status to 0/mem_ok.
  - Go to ISSUE0, or directly to DONE for op 11.
- ram_* outputs decode combinationally from state and latched request. rden and wren are never high together.
- Read word:
  - ISSUE0 (N+1): rden=1, addr=A.
  - CAPT0 (N+2): sample ram_q into rsp_data0 and ram_status into rsp_status.
  - DONE (N+3): done=1.
- Write word:
  - ISSUE0: wren=1, addr=A, data=wdata.
  - CAPT0: sample ram_status only; rsp_data0 stays 0.
  - DONE at N+3.
- Read cell (pipelined):
  - ISSUE0: rden=1, addr=A.
  - CAPT0: sample q/status for word 0; simultaneously rden=1, addr=A+1.
  - CAPT1: sample q into rsp_data1; rsp_status <= mem_oob if either sampled status was mem_oob.
  - DONE at N+4.
- Address wrap: if A is all ones, A+1 wraps. In CAPT0, rden is suppressed, rsp_data1 stays 0, and rsp_status is forced to mem_oob.
- OOB data: on mem_oob, the captured q (the RAM returns word 0) is stored unchanged; the consumer must check rsp_status.
- Illegal op 11: no RAM access; DONE at N+1 with rsp_status=mem_oob and data 0.
- Response hold: DONE lasts exactly one cycle, then IDLE. rsp_* hold their values until the next accept.
- Throughput: req_ready is low from ISSUE0 through DONE, so back-to-back word ops issue every 4 cycles and cells every 5.
- req_valid while busy is ignored; the request must be held by the requester.
- No combinational path from req_valid to ram_* outputs or to req_ready.

Test Plan:
- Reset mid cell read: assert rst in CAPT0 -> next cycle IDLE, req_ready=1, rden=0, no done, rsp_status=mem_ok, rsp_data* = 0.
- Write then read: write 0xDEADBEEF at addr 5 (done at N+3, status mem_ok), then read addr 5 -> rden high exactly one cycle, done at N+3, rsp_data0=0xDEADBEEF, mem_ok.
- Cell read: preload addr 10=0x11, 11=0x22 -> rden high in two consecutive cycles with addr 10 then 11, done at N+4, rsp_data0=0x11, rsp_data1=0x22, mem_ok.
- OOB read: read addr 200 (RAM depth 128) -> rsp_status=mem_oob, rsp_data0=RAM word 0. Cell read at addr 127 -> mem_oob, rsp_data0 = word 127.
- Wrap cell: cell read at addr 255 -> only one rden cycle, done at N+4, rsp_status=mem_oob, rsp_data1=0.
- Illegal op and busy: op 11 -> done at N+1, mem_oob, no strobes. req_valid held during a read -> second request accepted only in the cycle after DONE.
